// File: rtl/root_inject_arbiter_if.sv
// Bus bundle for root_inject_arbiter.
// Groups the requester handshake, the downstream LOCAL port and the upstream
// FIN/credit path.
//   master : packet sources and routers driving the arbiter
//   slave  : the arbiter itself
`ifndef ROUTER_INFO_FIN_BROADCAST
`define ROUTER_INFO_FIN_BROADCAST 4'hF
`endif

interface root_inject_arbiter_if #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned ROUTER_WIDTH = 36
);
  logic [NUM_REQ-1:0]              req_valid;
  logic [NUM_REQ*ROUTER_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]              req_grant;
  logic                            out_data_valid;
  logic [ROUTER_WIDTH-1:0]         out_data;
  logic                            downstream_credit;
  logic                            in_data_valid;
  logic [ROUTER_WIDTH-1:0]         in_data;
  logic                            upstream_credit;

  modport master (
    output req_valid, req_data, downstream_credit, in_data_valid, in_data,
    input  req_grant, out_data_valid, out_data, upstream_credit
  );

  modport slave (
    input  req_valid, req_data, downstream_credit, in_data_valid, in_data,
    output req_grant, out_data_valid, out_data, upstream_credit
  );
endinterface

// File: rtl/root_inject_arbiter.sv
// root_inject_arbiter
// Shares the root router's LOCAL downstream port among NUM_REQ packet sources
// using round-robin arbitration gated by downstream credits. It also terminates
// upstream FIN broadcasts, returns one credit per upstream packet and tracks
// which PEs have finished.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          requester handshake, downstream port, upstream path (slave)
//   clear_done   clear FIN bitmap and fin_count
//   fin_count    number of distinct PEs that reported FIN
//   all_done     fin_count == NUM_PE (registered)
//   err          sticky: [0] credit overflow, [1] non-FIN / bad-id upstream packet
module root_inject_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned ROUTER_WIDTH = 36,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned CREDIT_W     = 3,
  parameter int unsigned NUM_PE       = 16,
  parameter int unsigned PE_CNT_W     = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  root_inject_arbiter_if.slave    bus,
  input  logic                    clear_done,
  output logic [PE_CNT_W-1:0]     fin_count,
  output logic                    all_done,
  output logic [1:0]              err
);
  localparam int unsigned PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned PE_IDX_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam logic [CREDIT_W-1:0] DEPTH_C  = CREDIT_W'(FIFO_DEPTH);
  localparam logic [15:0]         NUM_PE_ID = 16'(NUM_PE);

  logic [CREDIT_W-1:0]     credit_q, credit_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic                    out_valid_q, out_valid_d;
  logic [ROUTER_WIDTH-1:0] out_data_q, out_data_d;
  logic                    upc_q, upc_d;
  logic [NUM_PE-1:0]       bitmap_q, bitmap_d;
  logic [PE_CNT_W-1:0]     fin_count_q, fin_count_d;
  logic                    all_done_q, all_done_d;
  logic [1:0]              err_q, err_d;

  logic [NUM_REQ-1:0]      req_grant_c;
  logic [PTR_W-1:0]        gnt_idx;
  logic                    gnt_found;

  logic [3:0]              in_info;
  logic [15:0]             in_id;
  logic                    unused_in_addr;

  assign in_info        = bus.in_data[35:32];
  assign in_id          = bus.in_data[15:0];
  assign unused_in_addr = ^bus.in_data[31:16];

  // Round-robin search starting at ptr; no grant without a downstream credit.
  always_comb begin : arb
    int unsigned idx;
    idx         = 0;
    req_grant_c = '0;
    gnt_idx     = '0;
    gnt_found   = 1'b0;
    if (credit_q != '0) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        idx = (32'(ptr_q) + k) % NUM_REQ;
        if (!gnt_found && bus.req_valid[idx]) begin
          gnt_found = 1'b1;
          gnt_idx   = PTR_W'(idx);
        end
      end
    end
    req_grant_c[gnt_idx] = gnt_found;
  end

  always_comb begin : next_state
    credit_d    = credit_q;
    ptr_d       = ptr_q;
    out_valid_d = gnt_found;
    out_data_d  = out_data_q;
    upc_d       = bus.in_data_valid;
    err_d       = err_q;

    if (gnt_found) begin
      out_data_d = bus.req_data[32'(gnt_idx)*ROUTER_WIDTH +: ROUTER_WIDTH];
      ptr_d      = PTR_W'((32'(gnt_idx) + 1) % NUM_REQ);
    end

    case ({gnt_found, bus.downstream_credit})
      2'b10: credit_d = credit_q - CREDIT_W'(1);
      2'b01: begin
        if (credit_q == DEPTH_C) err_d[0] = 1'b1;
        else                     credit_d = credit_q + CREDIT_W'(1);
      end
      default: credit_d = credit_q;
    endcase

    // Clear is applied before a same-cycle FIN so that FIN still counts.
    bitmap_d    = clear_done ? '0 : bitmap_q;
    fin_count_d = clear_done ? '0 : fin_count_q;
    if (bus.in_data_valid) begin
      if (in_info == `ROUTER_INFO_FIN_BROADCAST && in_id < NUM_PE_ID) begin
        if (!bitmap_d[in_id[PE_IDX_W-1:0]]) begin
          bitmap_d[in_id[PE_IDX_W-1:0]] = 1'b1;
          fin_count_d = fin_count_d + PE_CNT_W'(1);
        end
      end else begin
        err_d[1] = 1'b1;
      end
    end
    all_done_d = (fin_count_d == PE_CNT_W'(NUM_PE));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_q    <= DEPTH_C;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      upc_q       <= 1'b0;
      bitmap_q    <= '0;
      fin_count_q <= '0;
      all_done_q  <= 1'b0;
      err_q       <= '0;
    end else begin
      credit_q    <= credit_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      upc_q       <= upc_d;
      bitmap_q    <= bitmap_d;
      fin_count_q <= fin_count_d;
      all_done_q  <= all_done_d;
      err_q       <= err_d;
    end
  end

  assign bus.req_grant       = req_grant_c;
  assign bus.out_data_valid  = out_valid_q;
  assign bus.out_data        = out_data_q;
  assign bus.upstream_credit = upc_q;
  assign fin_count           = fin_count_q;
  assign all_done            = all_done_q;
  assign err                 = err_q;
endmodule

// File: tb/tb_root_inject_arbiter.sv
`ifndef ROUTER_INFO_FIN_BROADCAST
`define ROUTER_INFO_FIN_BROADCAST 4'hF
`endif

module tb_root_inject_arbiter;
  localparam int NR    = 4;
  localparam int RW    = 36;
  localparam int DEPTH = 4;
  localparam int NPE   = 16;
  localparam logic [3:0] FIN_T = `ROUTER_INFO_FIN_BROADCAST;
  localparam logic [3:0] CFG_T = 4'h1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear_done = 1'b0;
  logic [4:0] fin_count;
  logic       all_done;
  logic [1:0] err;

  int n_vec = 0;
  int n_err = 0;

  root_inject_arbiter_if #(.NUM_REQ(NR), .ROUTER_WIDTH(RW)) bus ();

  root_inject_arbiter #(
    .NUM_REQ(NR), .ROUTER_WIDTH(RW), .FIFO_DEPTH(DEPTH),
    .CREDIT_W(3), .NUM_PE(NPE), .PE_CNT_W(5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave), .clear_done(clear_done),
    .fin_count(fin_count), .all_done(all_done), .err(err)
  );

  always #5 clk = ~clk;

  // Reference model: credit count, rotating priority, set of finished PEs.
  int          m_credit;
  int          m_ptr;
  bit          m_ov;
  logic [RW-1:0] m_od;
  bit          m_upc;
  bit          m_done_pe [NPE];
  int          m_fin;
  bit          m_err0, m_err1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_credit = DEPTH; m_ptr = 0; m_ov = 0; m_od = '0; m_upc = 0;
    foreach (m_done_pe[i]) m_done_pe[i] = 0;
    m_fin = 0; m_err0 = 0; m_err1 = 0;
  endtask

  task automatic set_idle();
    bus.req_valid = '0; bus.req_data = '0; bus.downstream_credit = 1'b0;
    bus.in_data_valid = 1'b0; bus.in_data = '0; clear_done = 1'b0;
  endtask

  // Called at a falling edge with inputs set: checks all outputs, advances the
  // model across the next rising edge, returns at the following falling edge.
  task automatic cycle(output int gi);
    int g;
    logic [15:0] id;
    #1;
    g = -1;
    if (m_credit > 0)
      for (int k = 0; k < NR; k++)
        if (g < 0 && bus.req_valid[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
    chk("grant",     64'(bus.req_grant), (g < 0) ? 64'd0 : (64'd1 << g));
    chk("out_valid", 64'(bus.out_data_valid), 64'(m_ov));
    chk("out_data",  64'(bus.out_data), 64'(m_od));
    chk("up_credit", 64'(bus.upstream_credit), 64'(m_upc));
    chk("fin_count", 64'(fin_count), 64'(m_fin));
    chk("all_done",  64'(all_done), 64'(m_fin == NPE));
    chk("err",       64'(err), 64'({m_err1, m_err0}));

    m_upc = bus.in_data_valid;
    m_ov  = (g >= 0);
    if (g >= 0) begin
      m_od  = bus.req_data[g*RW +: RW];
      m_ptr = (g + 1) % NR;
    end
    if (g >= 0 && !bus.downstream_credit) m_credit--;
    else if (g < 0 && bus.downstream_credit) begin
      if (m_credit == DEPTH) m_err0 = 1;
      else m_credit++;
    end
    if (clear_done) foreach (m_done_pe[i]) m_done_pe[i] = 0;
    if (bus.in_data_valid) begin
      id = bus.in_data[15:0];
      if (bus.in_data[35:32] == FIN_T && id < NPE) m_done_pe[id] = 1;
      else m_err1 = 1;
    end
    m_fin = 0;
    foreach (m_done_pe[i]) m_fin += int'(m_done_pe[i]);
    gi = g;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_count(input int n, output int grants, output int upcs);
    int g;
    grants = 0; upcs = 0;
    for (int i = 0; i < n; i++) begin
      cycle(g);
      if (g >= 0) grants++;
      upcs += int'(bus.upstream_credit);
    end
  endtask

  initial begin : stim
    int g, ng, nu;
    int exp_seq [5];
    bit pend_v [NR];
    logic [RW-1:0] pend_d [NR];
    logic [31:0] r;
    exp_seq = '{0, 1, 2, 3, 0};

    set_idle();
    model_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: all requesting with credit returned each cycle -> 0,1,2,3,0
    for (int i = 0; i < NR; i++) bus.req_data[i*RW +: RW] = {4'(i + 1), 16'hA000 + 16'(i), 16'(i * 7)};
    bus.req_valid = '1;
    bus.downstream_credit = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle(g);
      chk("t1_order", 64'(g), 64'(exp_seq[i]));
    end

    // 2: no returns, req0 only -> four grants then stall; one return -> one more
    bus.req_valid = 4'b0001;
    bus.downstream_credit = 1'b0;
    run_count(6, ng, nu);
    chk("t2_grants", 64'(ng), 64'd4);
    bus.downstream_credit = 1'b1;
    cycle(g);
    bus.downstream_credit = 1'b0;
    run_count(4, ng, nu);
    chk("t2_one_more", 64'(ng), 64'd1);

    // 3: credit 2, grant+return together keeps 2; overflow at 4 sets err[0]
    bus.req_valid = '0;
    bus.downstream_credit = 1'b1;
    cycle(g); cycle(g);
    bus.req_valid = 4'b0001;
    cycle(g);
    bus.downstream_credit = 1'b0;
    run_count(4, ng, nu);
    chk("t3_credit2", 64'(ng), 64'd2);
    bus.req_valid = '0;
    bus.downstream_credit = 1'b1;
    for (int i = 0; i < 5; i++) cycle(g);
    bus.downstream_credit = 1'b0;
    cycle(g);
    chk("t3_err0", 64'(err[0]), 64'd1);
    bus.req_valid = 4'b0001;
    run_count(6, ng, nu);
    chk("t3_sat4", 64'(ng), 64'd4);
    bus.req_valid = '0;

    // 4: FIN from every PE, PE 5 twice
    nu = 0;
    for (int i = 0; i < NPE; i++) begin
      for (int rep = 0; rep < ((i == 5) ? 2 : 1); rep++) begin
        bus.in_data_valid = 1'b1;
        bus.in_data = {FIN_T, 16'h0, 16'(i)};
        cycle(g);
        nu += int'(bus.upstream_credit);
      end
    end
    bus.in_data_valid = 1'b0;
    cycle(g);
    nu += int'(bus.upstream_credit);
    chk("t4_upcredits", 64'(nu), 64'd17);
    chk("t4_fin16", 64'(fin_count), 64'd16);
    chk("t4_all_done", 64'(all_done), 64'd1);
    chk("t4_err1_clean", 64'(err[1]), 64'd0);

    // 5: clear with simultaneous FIN from PE 3; then a CONFIG packet
    clear_done = 1'b1;
    bus.in_data_valid = 1'b1;
    bus.in_data = {FIN_T, 16'h0, 16'd3};
    cycle(g);
    clear_done = 1'b0;
    bus.in_data = {CFG_T, 16'h1234, 16'd2};
    cycle(g);
    chk("t5_fin1", 64'(fin_count), 64'd1);
    chk("t5_not_done", 64'(all_done), 64'd0);
    bus.in_data_valid = 1'b0;
    cycle(g);
    chk("t5_err1", 64'(err[1]), 64'd1);
    chk("t5_fin_kept", 64'(fin_count), 64'd1);

    // Randomized traffic with requesters holding packets until granted
    foreach (pend_v[i]) pend_v[i] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!pend_v[i] && ($urandom_range(0, 2) != 0)) begin
          pend_v[i] = 1;
          pend_d[i] = {$urandom, $urandom};
        end
        bus.req_valid[i] = pend_v[i];
        bus.req_data[i*RW +: RW] = pend_v[i] ? pend_d[i] : '0;
      end
      bus.downstream_credit = ($urandom_range(0, 2) == 0);
      bus.in_data_valid = $urandom_range(0, 1);
      r = $urandom;
      bus.in_data = {($urandom_range(0, 3) != 0) ? FIN_T : 4'(r[31:28]),
                     r[27:12], 16'($urandom_range(0, 19))};
      clear_done = ($urandom_range(0, 39) == 0);
      cycle(g);
      if (g >= 0) pend_v[g] = 0;
    end

    // 6: asynchronous reset mid-stream
    bus.req_valid = '1;
    bus.downstream_credit = 1'b0;
    clear_done = 1'b0;
    bus.in_data_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 64'(bus.out_data_valid), 64'd0);
    chk("t6_rst_data", 64'(bus.out_data), 64'd0);
    chk("t6_rst_fin", 64'(fin_count), 64'd0);
    chk("t6_rst_err", 64'(err), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(g);
    chk("t6_restart_req0", 64'(g), 64'd0);
    run_count(5, ng, nu);
    chk("t6_credit4", 64'(ng), 64'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
